// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_multiplier
// Summary  : Iterative shift-add multiplier, one multiplier bit per clock.
//            Define MUL_SIGNED_EN for two's-complement operands.
// Revision : 1.0 - initial release
// ============================================================================
module shift_add_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   operand_A,
  input  logic [WIDTH-1:0]   operand_B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam logic [1:0]       c_IDLE = 2'd0;
  localparam logic [1:0]       c_RUN  = 2'd1;
  localparam logic [1:0]       c_FIN  = 2'd2;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_mq;
  logic               r_done;
  logic [2*WIDTH-1:0] r_result;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_cap_a;
  logic [WIDTH-1:0]   w_cap_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_final;
  logic               w_load;
  logic               w_step;
  logic               w_finish;

  // The carry of each add shifts into the accumulator MSB, so the
  // accumulator's extra top bit is always zero after the shift and is not kept.
  assign w_addend = r_mq[0] ? r_mcand : '0;
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_addend};
  assign w_prod   = {r_acc, r_mq};

`ifdef MUL_SIGNED_EN
  logic r_sign;

  // Magnitudes are unsigned WIDTH-bit values, so the most negative input still fits.
  assign w_cap_a = operand_A[WIDTH-1] ? -operand_A : operand_A;
  assign w_cap_b = operand_B[WIDTH-1] ? -operand_B : operand_B;
  assign w_final = r_sign ? -w_prod : w_prod;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sign <= 1'b0;
    end else if (w_load) begin
      r_sign <= operand_A[WIDTH-1] ^ operand_B[WIDTH-1];
    end
  end
`else
  assign w_cap_a = operand_A;
  assign w_cap_b = operand_B;
  assign w_final = w_prod;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (start) w_state_nxt = c_RUN;
      c_RUN:   if (r_cnt == c_LAST) w_state_nxt = c_FIN;
      c_FIN:   w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_load   = (r_state == c_IDLE) && start;
    w_step   = (r_state == c_RUN);
    w_finish = (r_state == c_FIN);
    busy     = (r_state != c_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mq     <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_mcand <= w_cap_a;
        r_mq    <= w_cap_b;
        r_acc   <= '0;
        r_cnt   <= '0;
      end else if (w_step) begin
        r_acc <= w_sum[WIDTH:1];
        r_mq  <= {w_sum[0], r_mq[WIDTH-1:1]};
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_finish) begin
        r_result <= w_final;
        r_done   <= 1'b1;
      end
    end
  end

  assign done   = r_done;
  assign result = r_result;

endmodule
`default_nettype wire

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
Iterative shift-add multiplier. It is the inverse companion to the team's shift-subtract divider, and the two are paired in the arithmetic sketch. It takes two WIDTH-bit operands on a start pulse and produces a 2*WIDTH-bit product after a fixed number of cycles. It examines one multiplier bit per clock, so one adder and no DSP blocks are needed. Intended for small CPU/ALU sketches where area matters more than latency.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH bits; must be >= 2
CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH

Ports:
clk        input   1          system clock, all logic on posedge
reset_n    input   1          synchronous reset, active-low
start      input   1          request; sampled only in IDLE
operand_A  input   WIDTH      multiplicand, captured on accepted start
operand_B  input   WIDTH      multiplier, captured on accepted start
busy       output  1          high while a multiplication is in progress
done       output  1          one-cycle pulse when product becomes valid
result     output  2*WIDTH    product; held stable from done until next accepted start

Behaviour:
- Clock and reset: one clock, clk. reset_n is synchronous and active-low, sampled on posedge clk.
- Reset values: busy=0, done=0, result=0, state=IDLE, counter=0, internal registers=0.
- Reset asserted mid-operation: the operation is aborted at that edge. busy, done and result clear to 0. No done is issued for the aborted operation.
- States: IDLE, RUN, FIN.
- IDLE:
  - start=1 captures operands, clears the accumulator and counter, sets busy=1 and moves to RUN.
  - start=0 stays in IDLE with all outputs held.
- RUN: one iteration per clock, for exactly WIDTH clocks (counter 0..WIDTH-1).
  - Datapath is a (2*WIDTH+1)-bit register {acc[WIDTH:0], mq[WIDTH-1:0]}; mq is initialised to operand_B.
  - Each iteration: sum = acc[WIDTH-1:0] + (mq[0] ? mcand : 0), a (WIDTH+1)-bit add that keeps the carry. Then {acc, mq} <= {1'b0, sum, mq} >> 1.
  - After iteration WIDTH-1, move to FIN.
- FIN (one cycle):
  - result <= {acc[WIDTH-1:0], mq}, done <= 1, busy <= 0, next state IDLE.
  - done is high for exactly one cycle. It drops on the following edge unless reset intervenes.
- Latency: with start sampled at edge E0, done and a valid result appear after edge E0+WIDTH+1, i.e. 33 cycles for WIDTH=32. busy is high from after E0 until after E0+WIDTH+1.
- Back-to-back: start is accepted in the cycle done is high (state is IDLE then). The new operation begins and result keeps the old value until the next FIN.
- start while busy=1 is ignored; no queuing. Operand inputs are don't-care outside the accepting cycle.
- Arithmetic: unsigned by default, result is the exact product modulo 2^(2*WIDTH). The carry bit of acc guarantees no overflow loss.
- Zero operands take the full latency; there is no early termination.

Optional Feature:
MUL_SIGNED_EN
- Defined: operands are two's complement.
  - At capture, mcand=|operand_A| and mq=|operand_B|, and sign=A[WIDTH-1]^B[WIDTH-1] is latched.
  - In FIN, the product is negated when sign=1.
  - Latency is unchanged.
  - The most negative operand works because its magnitude is held as an unsigned WIDTH-bit value.
- Not defined: pure unsigned. No sign or negation logic is synthesised.

Test Plan:
- Reset, then A=0x0080BABA, B=0x00000002, start pulse -> done exactly 33 cycles later, result=0x0000000001017574, busy high for those 33 cycles.
- A=0xFFFFFFFF, B=0xFFFFFFFF (unsigned build) -> result=0xFFFFFFFE00000001. With A=0, B=0x12345678 -> result=0, latency still 33.
- A=0xFFFFFFFE, B=3. Unsigned build -> result=0x00000002FFFFFFFA. MUL_SIGNED_EN build -> result=0xFFFFFFFFFFFFFFFA (-6). Signed A=B=0x80000000 -> 0x4000000000000000.
- Pulse start again at cycles 5 and 20 with different operands while busy -> ignored; only the first product is reported, one done pulse.
- start asserted in the done cycle with A=7, B=6 -> previous result held until the new done 33 cycles later, then result=0x2A.
- Drop reset_n at cycle 10 of RUN -> next edge busy=0, result=0, no done. Fresh start afterwards gives the correct product.
